// File: rtl/decode_stage.sv
// decode_stage: RV32I decoder feeding a DEPTH-entry output FIFO.
// Ports: clk, rst_n (async, active low), flush;
//   in_valid/in_ready/in_instr/in_pc (upstream handshake);
//   out_valid/out_ready/out_aluop/out_werf/out_rd/out_rs1/out_rs2/
//   out_imm/out_pc/out_illegal (downstream handshake, head entry).
// Optional: define DECODE_RV32M_EN to decode the RV32M extension.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int AOPW  = 6,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [AOPW-1:0] out_aluop,
   output logic            out_werf,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   typedef struct packed {
      logic [AOPW-1:0] aluop;
      logic            werf;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic            illegal;
   } entry_t;

   // ---------------- decode ----------------
   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rd;

   assign opc = in_instr[6:0];
   assign f3  = in_instr[14:12];
   assign f7  = in_instr[31:25];
   assign rd  = in_instr[11:7];

   logic is_r, is_i, is_ld, is_jalr;
   logic is_st, is_br, is_jal, is_lui, is_aui;

   assign is_r    = (opc == 7'b0110011);
   assign is_i    = (opc == 7'b0010011);
   assign is_ld   = (opc == 7'b0000011);
   assign is_jalr = (opc == 7'b1100111);
   assign is_st   = (opc == 7'b0100011);
   assign is_br   = (opc == 7'b1100011);
   assign is_jal  = (opc == 7'b1101111);
   assign is_lui  = (opc == 7'b0110111);
   assign is_aui  = (opc == 7'b0010111);

   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25],
                   in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31],
                   in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

   logic [5:0]      op6;
   logic            wcls;
   logic [XLEN-1:0] imm_raw;

   always_comb begin
      op6     = '0;
      wcls    = 1'b0;
      imm_raw = '0;
      unique case (1'b1)
         is_r: begin
            wcls = 1'b1;
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0: op6 = 6'd1;
                  3'd1: op6 = 6'd6;
                  3'd2: op6 = 6'd9;
                  3'd3: op6 = 6'd10;
                  3'd4: op6 = 6'd3;
                  3'd5: op6 = 6'd7;
                  3'd6: op6 = 6'd4;
                  3'd7: op6 = 6'd5;
                  default: ;
               endcase
            end else if (f7 == 7'h20) begin
               case (f3)
                  3'd0: op6 = 6'd2;
                  3'd5: op6 = 6'd8;
                  default: ;
               endcase
            end
`ifdef DECODE_RV32M_EN
            else if (f7 == 7'h01) begin
               op6 = 6'd38 + 6'(f3);
            end
`endif
         end
         is_i: begin
            wcls    = 1'b1;
            imm_raw = imm_i;
            case (f3)
               3'd0: op6 = 6'd11;
               3'd4: op6 = 6'd12;
               3'd6: op6 = 6'd13;
               3'd7: op6 = 6'd14;
               3'd2: op6 = 6'd18;
               3'd3: op6 = 6'd19;
               // shifts: only bit 30 may be set in funct7
               3'd1: op6 = (f7 == 7'h00) ? 6'd15 : 6'd0;
               3'd5: begin
                  if (f7 == 7'h00)      op6 = 6'd16;
                  else if (f7 == 7'h20) op6 = 6'd17;
               end
               default: ;
            endcase
         end
         is_ld: begin
            wcls    = 1'b1;
            imm_raw = imm_i;
            case (f3)
               3'd0: op6 = 6'd20;
               3'd1: op6 = 6'd21;
               3'd2: op6 = 6'd22;
               3'd4: op6 = 6'd23;
               3'd5: op6 = 6'd24;
               default: ;
            endcase
         end
         is_jalr: begin
            wcls    = 1'b1;
            imm_raw = imm_i;
            if (f3 == 3'd0) op6 = 6'd25;
         end
         is_st: begin
            imm_raw = imm_s;
            case (f3)
               3'd0: op6 = 6'd26;
               3'd1: op6 = 6'd27;
               3'd2: op6 = 6'd28;
               default: ;
            endcase
         end
         is_br: begin
            imm_raw = imm_b;
            case (f3)
               3'd0: op6 = 6'd29;
               3'd1: op6 = 6'd30;
               3'd4: op6 = 6'd31;
               3'd5: op6 = 6'd32;
               3'd6: op6 = 6'd33;
               3'd7: op6 = 6'd34;
               default: ;
            endcase
         end
         is_jal: begin
            wcls    = 1'b1;
            imm_raw = imm_j;
            op6     = 6'd35;
         end
         is_lui: begin
            wcls    = 1'b1;
            imm_raw = imm_u;
            op6     = 6'd36;
         end
         is_aui: begin
            wcls    = 1'b1;
            imm_raw = imm_u;
            op6     = 6'd37;
         end
         default: ;
      endcase
   end

   // aluop 0 is reserved for "no match"
   entry_t dec;

   always_comb begin
      dec         = '0;
      dec.illegal = (op6 == 6'd0);
      dec.aluop   = AOPW'(op6);
      dec.werf    = wcls && !dec.illegal && (rd != 5'd0);
      dec.rd      = rd;
      dec.rs1     = in_instr[19:15];
      dec.rs2     = in_instr[24:20];
      dec.imm     = dec.illegal ? '0 : imm_raw;
      dec.pc      = in_pc;
   end

   // ---------------- queue ----------------
   entry_t        mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= dec;
            wptr      <= nxt(wptr);
         end
         if (pop) rptr <= nxt(rptr);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // outputs read zero whenever nothing is presented
   entry_t head;

   assign head = out_valid ? mem[rptr] : '0;

   assign out_aluop   = head.aluop;
   assign out_werf    = head.werf;
   assign out_rd      = head.rd;
   assign out_rs1     = head.rs1;
   assign out_rs2     = head.rs2;
   assign out_imm     = head.imm;
   assign out_pc      = head.pc;
   assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (DEPTH=2).
// Expected entries are queued at accept; a monitor checks the head.
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_aluop;
   logic        out_werf;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [31:0] out_imm;
   logic [31:0] out_pc;
   logic        out_illegal;

   decode_stage #(.XLEN(32), .AOPW(6), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_aluop(out_aluop), .out_werf(out_werf),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm(out_imm), .out_pc(out_pc),
      .out_illegal(out_illegal)
   );

   typedef struct packed {
      logic [5:0]  aluop;
      logic        werf;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        illegal;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input int op, input bit w,
                               input int rd, input int rs1,
                               input int rs2, input logic [31:0] imm,
                               input bit ill);
      exp_t e;
      e.aluop   = 6'(op);
      e.werf    = w;
      e.rd      = 5'(rd);
      e.rs1     = 5'(rs1);
      e.rs2     = 5'(rs2);
      e.imm     = imm;
      e.pc      = '0;
      e.illegal = ill;
      return e;
   endfunction

   // monitor: pops on handshake, checks hold and idle-zero otherwise
   exp_t act;
   always @(negedge clk) begin
      act = {out_aluop, out_werf, out_rd, out_rs1, out_rs2,
             out_imm, out_pc, out_illegal};
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            chk(out_ready ? "pop" : "hold", act, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
         end
      end else begin
         chk("idle_zero", act, '0);
      end
   end

   // called just after a rising edge; returns just after one
   task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                       input exp_t e);
      bit done = 0;
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      e.pc     = pc;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   exp_t e_mul;

   initial begin
`ifdef DECODE_RV32M_EN
      e_mul = mk(38, 1, 2, 1, 2, 32'h0, 0);
`else
      e_mul = mk(0, 0, 2, 1, 2, 32'h0, 1);
`endif
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b1;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // add: visible one cycle after accept
      send(32'h002081B3, 32'h100, mk(1, 1, 3, 1, 2, 32'h0, 0));
      chk("latency", out_valid, 1);

      send(32'h402081B3, 32'h104, mk(2, 1, 3, 1, 2, 32'h0, 0));
      send(32'h00000013, 32'h108, mk(11, 0, 0, 0, 0, 32'h0, 0));
      send(32'hFFF00093, 32'h10C,
           mk(11, 1, 1, 0, 31, 32'hFFFFFFFF, 0));
      send(32'hFFFFFFFF, 32'h110, mk(0, 0, 31, 31, 31, 32'h0, 1));
      send(32'h02208133, 32'h114, e_mul);
      send(32'h123452B7, 32'h118,
           mk(36, 1, 5, 8, 3, 32'h12345000, 0));
      send(32'h0020A423, 32'h11C, mk(28, 0, 8, 1, 2, 32'h8, 0));
      send(32'hFE208EE3, 32'h120,
           mk(29, 0, 29, 1, 2, 32'hFFFFFFFC, 0));
      send(32'h008000EF, 32'h124, mk(35, 1, 1, 0, 8, 32'h8, 0));
      send(32'h4030D093, 32'h128, mk(17, 1, 1, 1, 3, 32'h403, 0));
      send(32'h40109093, 32'h12C, mk(0, 0, 1, 1, 1, 32'h0, 1));
      send(32'hFFF12203, 32'h130,
           mk(22, 1, 4, 2, 31, 32'hFFFFFFFF, 0));
      send(32'h00001017, 32'h134, mk(37, 0, 0, 0, 0, 32'h1000, 0));
      drain();

      // backpressure: third valid must stall while full
      out_ready = 1'b0;
      send(32'h002081B3, 32'h200, mk(1, 1, 3, 1, 2, 32'h0, 0));
      send(32'h402081B3, 32'h204, mk(2, 1, 3, 1, 2, 32'h0, 0));
      in_valid = 1'b1;
      in_instr = 32'h00000013;
      in_pc    = 32'h208;
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_no_accept", in_ready, 0);
      @(posedge clk);
      #1;
      send(32'h00000013, 32'h208, mk(11, 0, 0, 0, 0, 32'h0, 0));
      drain();

      // flush with a same-cycle valid drops everything
      out_ready = 1'b0;
      send(32'h002081B3, 32'h300, mk(1, 1, 3, 1, 2, 32'h0, 0));
      send(32'h402081B3, 32'h304, mk(2, 1, 3, 1, 2, 32'h0, 0));
      in_valid = 1'b1;
      in_instr = 32'hFFF00093;
      in_pc    = 32'h308;
      flush    = 1'b1;
      @(posedge clk);
      exp_q.delete();
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      out_ready = 1'b1;
      send(32'h123452B7, 32'h30C,
           mk(36, 1, 5, 8, 3, 32'h12345000, 0));
      drain();

      // reset in the middle of a transfer
      out_ready = 1'b0;
      send(32'h0020A423, 32'h400, mk(28, 0, 8, 1, 2, 32'h8, 0));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_ready", in_ready, 1);
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send(32'h008000EF, 32'h404, mk(35, 1, 1, 0, 8, 32'h8, 0));
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
